// File: rtl/alu_pkg.sv
// alu_pkg: alu opcode encoding plus scheduler state and sizing constants.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
  localparam int MAX_NUM_REQ = 8;
endpackage

// File: rtl/alu.sv
// alu: combinational integer alu with zero, signed-overflow and negative flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  alu_op_t          opcode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);
  logic [WIDTH-1:0] sum, diff;
  assign sum  = in0 + in1;
  assign diff = in0 - in1;
  always_comb begin
    case (opcode)
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_AND:  result = in0 & in1;
      ALU_OR:   result = in0 | in1;
      ALU_XOR:  result = in0 ^ in1;
      ALU_SLL:  result = in0 << in1[4:0];
      ALU_SRL:  result = in0 >> in1[4:0];
      ALU_SRA:  result = WIDTH'($signed(in0) >>> in1[4:0]);
      ALU_SLT:  result = WIDTH'($signed(in0) < $signed(in1));
      ALU_SLTU: result = WIDTH'(in0 < in1);
      default:  result = '0;
    endcase
  end
  assign zero     = result == '0;
  assign negative = result[WIDTH-1];
  assign overflow = opcode == ALU_ADD ? (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]) :
                    opcode == ALU_SUB ? (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]) :
                    1'b0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);
  logic found;
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_grant) + i) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = IDXW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end
  assign gnt = found ? NUM_REQ'(1) << gnt_idx : '0;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one alu among NUM_REQ requesters, one op in flight.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_in0,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_in1,
  input  alu_op_t [NUM_REQ-1:0]           req_opcode,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [WIDTH-1:0]                rsp_result,
  output logic                            rsp_zero,
  output logic                            rsp_overflow,
  output logic                            rsp_negative,
  output logic                            busy
);
  localparam int IDXW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("alu_scheduler: NUM_REQ out of range");
  end
  sched_state_t     state_q, state_d;
  logic [IDXW-1:0]  grant_q, grant_d, last_q, last_d, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [WIDTH-1:0] in0_q, in0_d, in1_q, in1_d, result_q, result_d, alu_res;
  alu_op_t          op_q, op_d;
  logic [2:0]       flags_q, flags_d;
  logic             alu_zero, alu_ovf, alu_neg;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req(req_valid), .last_grant(last_q), .gnt(arb_gnt), .gnt_idx(arb_idx)
  );
  // The alu only ever sees the captured operands, so late port changes cannot leak in.
  alu #(.WIDTH(WIDTH)) u_alu (
    .in0(in0_q), .in1(in1_q), .opcode(op_q),
    .result(alu_res), .zero(alu_zero), .overflow(alu_ovf), .negative(alu_neg)
  );
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (state_q == IDLE && |req_valid) begin
      state_d = EXEC;
      grant_d = arb_idx;
      in0_d   = req_in0[arb_idx];
      in1_d   = req_in1[arb_idx];
      op_d    = req_opcode[arb_idx];
    end
    if (state_q == EXEC) begin
      state_d  = RESP;
      result_d = alu_res;
      flags_d  = {alu_zero, alu_ovf, alu_neg};
    end
    if (state_q == RESP && rsp_ready[grant_q]) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDXW'(NUM_REQ - 1);
      in0_q    <= '0;
      in1_q    <= '0;
      op_q     <= ALU_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
  assign req_ready    = state_q == IDLE ? arb_gnt : '0;
  assign rsp_valid    = state_q == RESP ? NUM_REQ'(1) << grant_q : '0;
  assign busy         = state_q != IDLE;
  assign rsp_result   = result_q;
  assign rsp_zero     = flags_q[2];
  assign rsp_overflow = flags_q[1];
  assign rsp_negative = flags_q[0];
endmodule
